// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family (counter, prescaler, timer).
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // True when a modulus fits the counter width.
    // The check runs in 64-bit arithmetic so 2**width never truncates.
    function automatic bit modulus_legal(input int width, input longint modulus);
        if (width < 1 || width > 62) begin
            return 1'b0;
        end
        return (modulus >= 64'sd2) && (modulus <= (64'sd1 <<< width));
    endfunction

endpackage

// File: rtl/counter_next.sv
// Next-state and flag logic for the up/down modulo counter.
// Purely combinational; the top level owns all registers.
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_next,
    output logic             wrap,
    output logic             tc,
    output logic             load_bad
);

    // One spare bit keeps MODULUS == 2**WIDTH from aliasing the last count to 0.
    localparam logic [WIDTH:0] LAST     = (WIDTH+1)'(MODULUS - 1);
    localparam logic           SAT_MODE = (SATURATE == MODE_SAT);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] inc_ext;
    logic [WIDTH:0] dec_ext;
    logic [WIDTH:0] val_ext;
    logic           at_last;
    logic           at_zero;
    logic           at_bound;
    logic           val_over;
    logic           count_req;

    // Extended arithmetic: overflow past LAST and borrow below 0 are read from the spare bit.
    always_comb begin
        q_ext     = {1'b0, q};
        inc_ext   = q_ext + (WIDTH+1)'(1);
        dec_ext   = q_ext - (WIDTH+1)'(1);
        val_ext   = {1'b0, load_val};
        at_last   = (inc_ext > LAST);
        at_zero   = dec_ext[WIDTH];
        val_over  = (val_ext > LAST);
        at_bound  = (up == DIR_UP) ? at_last : at_zero;
        count_req = en & ~clr & ~load;
    end

    // Flags: clear and load both mask counting, so neither tc nor wrap can fire with them.
    always_comb begin
        tc       = count_req & at_bound;
        wrap     = count_req & at_bound & ~SAT_MODE;
        load_bad = ~clr & load & val_over;
    end

    // Next count, priority clr > load > en; holding is the default.
    always_comb begin
        q_next = q;
        if (clr) begin
            q_next = '0;
        end else if (load) begin
            q_next = val_over ? LAST[WIDTH-1:0] : load_val;
        end else if (en) begin
            if (up == DIR_UP) begin
                if (!at_last) begin
                    q_next = inc_ext[WIDTH-1:0];
                end else if (!SAT_MODE) begin
                    q_next = '0;
                end
            end else begin
                if (!at_zero) begin
                    q_next = dec_ext[WIDTH-1:0];
                end else if (!SAT_MODE) begin
                    q_next = LAST[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Synchronous up/down modulo-N counter with clear, load, enable and tc/ovf flags.
// Cascade by driving the next stage's en from this stage's tc.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             load_err
);

    // Refuse to elaborate with a modulus that cannot be represented.
    if (!modulus_legal(WIDTH, longint'(MODULUS))) begin : g_bad_modulus
        $error("updown_mod_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
    end
    if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
        $error("updown_mod_counter: SATURATE must be 0 or 1, got %0d", SATURATE);
    end

    logic [WIDTH-1:0] q_next;
    logic             wrap;
    logic             load_bad;

    counter_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .q        (q),
        .up       (up),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .q_next   (q_next),
        .wrap     (wrap),
        .tc       (tc),
        .load_bad (load_bad)
    );

    // Count register and one-cycle flag pulses; reset cancels any pending pulse at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= '0;
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            q        <= q_next;
            ovf      <= wrap;
            load_err <= load_bad;
        end
    end

endmodule
